// File: rtl/vend_ctrl_param.sv
// -----------------------------------------------------------------------------
// vend_ctrl_param
//
// Parametrised beverage vending controller. Accumulates coin credit, checks a
// one-hot product selection against a runtime price table, drives the chosen
// product's dispense line for a timed interval, then returns change and goes
// back to idle. Sits between the coin/keypad front end and the valve drivers.
//
// Optional feature macro: SUGAR_OPT_EN
//   When defined, adds the sugar_req input (latched with an accepted selection)
//   and the sugar output (high during the final dispense tick when requested).
//
// Parameters
//   NUM_COINS   coin inputs; coin i is worth 2**i credit units
//   NUM_PROD    number of products; width of sel and dispense
//   CREDIT_W    credit/price/change width
//   TICK_DIV    clk cycles per timer tick (>=1)
//   DISP_TICKS  dispense duration in ticks (>=1)
//
// Ports
//   clk           in   rising-edge system clock
//   reset         in   asynchronous active-low reset
//   coin_in       in   one-cycle coin pulses, simultaneous coins are summed
//   cancel        in   abort and return credit (honoured in CREDIT only)
//   sel           in   product request, must be one-hot
//   price_tbl     in   price of product p at [p*CREDIT_W +: CREDIT_W]
//   sugar_req     in   (SUGAR_OPT_EN) sugar wanted with this selection
//   credit        out  current credit
//   dispense      out  one-hot active product
//   change        out  change amount, valid with change_valid
//   change_valid  out  one-cycle change pulse
//   coin_reject   out  one-cycle pulse, coins refused
//   sel_err       out  one-cycle pulse, bad or unaffordable selection
//   busy          out  high while dispensing or returning change
//   ticks         out  elapsed dispense ticks
//   sugar         out  (SUGAR_OPT_EN) sugar valve during final dispense tick
// -----------------------------------------------------------------------------
module vend_ctrl_param #(
    parameter int NUM_COINS  = 2,
    parameter int NUM_PROD   = 4,
    parameter int CREDIT_W   = 4,
    parameter int TICK_DIV   = 4,
    parameter int DISP_TICKS = 3
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_COINS-1:0]             coin_in,
    input  logic                             cancel,
    input  logic [NUM_PROD-1:0]              sel,
    input  logic [NUM_PROD*CREDIT_W-1:0]     price_tbl,
`ifdef SUGAR_OPT_EN
    input  logic                             sugar_req,
    output logic                             sugar,
`endif
    output logic [CREDIT_W-1:0]              credit,
    output logic [NUM_PROD-1:0]              dispense,
    output logic [CREDIT_W-1:0]              change,
    output logic                             change_valid,
    output logic                             coin_reject,
    output logic                             sel_err,
    output logic                             busy,
    output logic [$clog2(DISP_TICKS+1)-1:0]  ticks
);

    // A one-bit divider is still needed when TICK_DIV is 1 so the vector is legal.
    localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TICK_W = $clog2(DISP_TICKS + 1);
    // Sum width covers both the credit and the largest coin total plus a carry.
    localparam int SUM_W  = ((CREDIT_W > NUM_COINS) ? CREDIT_W : NUM_COINS) + 1;

    localparam logic [SUM_W-1:0]  MAX_CREDIT = SUM_W'((2 ** CREDIT_W) - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(TICK_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(DISP_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CREDIT   = 2'd1,
        DISPENSE = 2'd2,
        CHANGE   = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CREDIT_W-1:0]  credit_q, credit_d;
    logic [CREDIT_W-1:0]  price_q, price_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [NUM_PROD-1:0]  disp_q, disp_d;
    logic [CREDIT_W-1:0]  change_q, change_d;
    logic                 change_valid_q, change_valid_d;
    logic                 coin_reject_q, coin_reject_d;
    logic                 sel_err_q, sel_err_d;
`ifdef SUGAR_OPT_EN
    logic                 sugar_lat_q, sugar_lat_d;
`endif

    logic [SUM_W-1:0]     coin_sum;
    logic [SUM_W-1:0]     credit_sum;
    logic                 coin_any;
    logic                 coin_fits;
    logic [CREDIT_W-1:0]  sel_price;
    logic                 sel_onehot;

    // Coin i is worth 2**i units; every coin asserted this cycle is summed.
    always_comb begin
        coin_sum = '0;
        for (int i = 0; i < NUM_COINS; i++) begin
            if (coin_in[i]) begin
                coin_sum = coin_sum + (SUM_W'(1) << i);
            end
        end
    end

    assign coin_any   = (coin_in != '0);
    assign credit_sum = SUM_W'(credit_q) + coin_sum;
    assign coin_fits  = (credit_sum <= MAX_CREDIT);

    // Price lookup for the requested product. Only meaningful when sel is
    // one-hot; a multi-hot sel is rejected before this value is used.
    always_comb begin
        sel_price = '0;
        for (int p = 0; p < NUM_PROD; p++) begin
            if (sel[p]) begin
                sel_price = price_tbl[p*CREDIT_W +: CREDIT_W];
            end
        end
    end

    assign sel_onehot = $onehot(sel);

    // Next-state and registered-output logic. Pulse outputs default to 0 so
    // they only last the single cycle after the event that raised them.
    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        price_d        = price_q;
        div_d          = div_q;
        tick_d         = tick_q;
        disp_d         = disp_q;
        change_d       = '0;
        change_valid_d = 1'b0;
        coin_reject_d  = 1'b0;
        sel_err_d      = 1'b0;
`ifdef SUGAR_OPT_EN
        sugar_lat_d    = sugar_lat_q;
`endif

        unique case (state_q)
            IDLE, CREDIT: begin
                if (cancel && (state_q == CREDIT)) begin
                    // Cancel overrides any selection; credit is being
                    // refunded, so coins arriving alongside are refused.
                    state_d        = CHANGE;
                    change_d       = credit_q;
                    change_valid_d = 1'b1;
                    coin_reject_d  = coin_any;
                end else begin
                    // Coins are added in the same cycle as a selection, but the
                    // affordability check below uses the pre-coin credit.
                    if (coin_any) begin
                        if (coin_fits) begin
                            credit_d = credit_sum[CREDIT_W-1:0];
                        end else begin
                            coin_reject_d = 1'b1;
                        end
                    end

                    if ((sel != '0) && sel_onehot && (sel_price <= credit_q)) begin
                        state_d = DISPENSE;
                        disp_d  = sel;
                        price_d = sel_price;
                        div_d   = '0;
                        tick_d  = '0;
`ifdef SUGAR_OPT_EN
                        sugar_lat_d = sugar_req;
`endif
                    end else begin
                        sel_err_d = (sel != '0);
                        state_d   = (credit_d != '0) ? CREDIT : IDLE;
                    end
                end
            end

            DISPENSE: begin
                coin_reject_d = coin_any;
                if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    tick_d = tick_q + 1'b1;
                    if (tick_q == TICK_LAST) begin
                        state_d        = CHANGE;
                        disp_d         = '0;
                        change_d       = credit_q - price_q;
                        change_valid_d = 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            CHANGE: begin
                coin_reject_d = coin_any;
                state_d       = IDLE;
                credit_d      = '0;
                price_d       = '0;
                div_d         = '0;
                tick_d        = '0;
                disp_d        = '0;
`ifdef SUGAR_OPT_EN
                sugar_lat_d   = 1'b0;
`endif
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any transaction and drops
    // the credit without a change pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            credit_q       <= '0;
            price_q        <= '0;
            div_q          <= '0;
            tick_q         <= '0;
            disp_q         <= '0;
            change_q       <= '0;
            change_valid_q <= 1'b0;
            coin_reject_q  <= 1'b0;
            sel_err_q      <= 1'b0;
`ifdef SUGAR_OPT_EN
            sugar_lat_q    <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            price_q        <= price_d;
            div_q          <= div_d;
            tick_q         <= tick_d;
            disp_q         <= disp_d;
            change_q       <= change_d;
            change_valid_q <= change_valid_d;
            coin_reject_q  <= coin_reject_d;
            sel_err_q      <= sel_err_d;
`ifdef SUGAR_OPT_EN
            sugar_lat_q    <= sugar_lat_d;
`endif
        end
    end

    assign credit       = credit_q;
    assign dispense     = disp_q;
    assign change       = change_q;
    assign change_valid = change_valid_q;
    assign coin_reject  = coin_reject_q;
    assign sel_err      = sel_err_q;
    assign busy         = (state_q == DISPENSE) || (state_q == CHANGE);
    assign ticks        = tick_q;

`ifdef SUGAR_OPT_EN
    // Decoded from registers only, so it is glitch-free and 0 out of reset.
    assign sugar = sugar_lat_q && (state_q == DISPENSE) && (tick_q == TICK_LAST);
`endif

endmodule
